tstamp_gen: RTL

- Upstream front end of the gain-clock stage.
- Divides clk_main down to clk_low.
- Synchronises an asynchronous spike input and qualifies it with the exposure window exp_w1.
- Emits one clk_low-aligned timestamp pulse (tstamp) and its one-clk_low-period delayed copy (tstamp_de), followed by a refractory interval. Also supplies the clk_main-delayed exp_w1_de1.
- All outputs feed the gain-clock generator directly.

---
 rtl/tstamp_gen.sv | 116 +++++++++++
 1 files changed

// File: rtl/tstamp_gen.sv
// rtl/tstamp_gen.sv - clk_low divider, spike synchroniser and timestamp pulse generator
// Feeds the gain-clock generator: clk_low, tstamp, tstamp_de, exp_w1_de1.
module tstamp_gen #(
  parameter int R_MAIN_TO_LOW = 1000,
  parameter int REFRAC_LOW    = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk_main,
  input  logic             clr,
  input  logic             spike_in,
  input  logic             exp_w1,
  output logic             clk_low,
  output logic             tstamp,
  output logic             tstamp_de,
  output logic             exp_w1_de1,
  output logic             busy,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int DW = $clog2(R_MAIN_TO_LOW);
  localparam int RW = (REFRAC_LOW < 1) ? 1 : $clog2(REFRAC_LOW + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(R_MAIN_TO_LOW - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(R_MAIN_TO_LOW / 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PEND   = 2'd1;
  localparam logic [1:0] S_STAMP  = 2'd2;
  localparam logic [1:0] S_REFRAC = 2'd3;

  logic [DW-1:0]          div_cnt;
  logic [DW-1:0]          div_nxt;
  logic                   low_tick;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ev_q;
  logic                   ev_rise;
  logic                   drop_hit;
  logic [1:0]             state;
  logic [1:0]             state_nxt;
  logic [RW-1:0]          ref_cnt;
  logic [RW-1:0]          ref_nxt;
  logic                   tstamp_nxt;

  // low_tick marks the cycle whose closing edge raises clk_low
  assign low_tick = (div_cnt == DIV_LAST);
  assign div_nxt  = low_tick ? '0 : div_cnt + 1'b1;
  assign ev_rise  = sync_q[SYNC_STAGES-1] & ~ev_q;
  assign drop_hit = ev_rise & exp_w1 & (state != S_IDLE);

  always_comb begin
    state_nxt  = state;
    ref_nxt    = ref_cnt;
    tstamp_nxt = tstamp;
    case (state)
      S_IDLE: begin
        if (ev_rise && exp_w1) state_nxt = S_PEND;
      end
      S_PEND: begin
        // losing the window cancels before any stamp, even on a low_tick
        if (!exp_w1) begin
          state_nxt = S_IDLE;
        end else if (low_tick) begin
          tstamp_nxt = 1'b1;
          state_nxt  = S_STAMP;
        end
      end
      S_STAMP: begin
        if (low_tick) begin
          tstamp_nxt = 1'b0;
          if (REFRAC_LOW == 0) begin
            state_nxt = S_IDLE;
          end else begin
            ref_nxt   = RW'(REFRAC_LOW);
            state_nxt = S_REFRAC;
          end
        end
      end
      S_REFRAC: begin
        if (low_tick) begin
          ref_nxt = ref_cnt - 1'b1;
          if (ref_cnt == RW'(1)) state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_main or posedge clr) begin
    if (clr) begin
      div_cnt    <= DIV_LAST;
      clk_low    <= 1'b0;
      sync_q     <= '0;
      ev_q       <= 1'b0;
      exp_w1_de1 <= 1'b0;
      state      <= S_IDLE;
      busy       <= 1'b0;
      ref_cnt    <= '0;
      tstamp     <= 1'b0;
      tstamp_de  <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      div_cnt    <= div_nxt;
      clk_low    <= (div_nxt < DIV_HALF);
      sync_q     <= {sync_q[SYNC_STAGES-2:0], spike_in};
      ev_q       <= sync_q[SYNC_STAGES-1];
      exp_w1_de1 <= exp_w1;
      state      <= state_nxt;
      busy       <= (state_nxt != S_IDLE);
      ref_cnt    <= ref_nxt;
      tstamp     <= tstamp_nxt;
      if (low_tick) tstamp_de <= tstamp;
      if (drop_hit && (drop_cnt != '1)) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule
